// File: rtl/piso_tx_buff.sv
// Parallel-in, serial-out transmit buffer: captures a word on start_i and sends
// it as an asynchronous frame (start bit low, Width data bits LSB first, stop bit high).
module piso_tx_buff #(
  parameter int Width      = 8,
  parameter int ClksPerBit = 434
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [Width-1:0] din_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  // Handshake: start_i is a request that is taken only while busy_o is low
  // (IDLE); requests made while busy_o is high are dropped, never queued.
  // done_o pulses for one cycle in the first IDLE cycle after the stop bit.

  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int IdxW = (Width > 1) ? $clog2(Width) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Width - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state_q;
  logic [Width-1:0] shift_q;
  logic [Width-1:0] shift_next;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  assign bit_end    = (cnt_q == CntLast);
  assign shift_next = shift_q >> 1;

  // tx/busy are loaded with the value of the state being entered, so every
  // output is a plain flop with no path back to the inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i) begin
          shift_q <= din_i;
          cnt_q   <= '0;
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
      end else if (!bit_end) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        case (state_q)
          START: begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
          DATA: begin
            if (idx_q == IdxLast) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_next;
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_next[0];
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_piso_tx_buff.sv
// Directed bench for piso_tx_buff with Width=8, ClksPerBit=4 (40-cycle frames).
module tb_piso_tx_buff;

  logic       clk;
  logic       rst;
  logic       start;
  logic       clear;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  piso_tx_buff #(.Width(8), .ClksPerBit(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .clear_i (clear),
    .din_i   (din),
    .tx_o    (tx),
    .busy_o  (busy),
    .done_o  (done),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame patterns: bit b is the line level during frame bit b (b=0 start, b=9 stop).
  localparam logic [9:0] FR_A5 = 10'b1101001010;
  localparam logic [9:0] FR_3C = 10'b1001111000;
  localparam logic [9:0] FR_81 = 10'b1100000010;
  localparam logic [9:0] FR_00 = 10'b1000000000;
  localparam logic [9:0] FR_FF = 10'b1111111110;
  localparam logic [9:0] FR_55 = 10'b1010101010;

  task automatic chk(input string name, input int c, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", name, c, act, exp);
    end
  endtask

  // Caller is at a negedge. Accept edge is the next posedge (edge 0);
  // samples are taken at the negedge inside each cycle.
  task automatic send_frame(input string name, input logic [7:0] d,
                            input logic [9:0] fr, input int poke);
    din   = d;
    start = 1'b1;
    for (int c = 0; c <= 44; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        din   = ~d;
      end
      if (c == poke) begin
        start = 1'b1;
        din   = 8'hFF;
      end
      if (c == poke + 1) start = 1'b0;
      chk({name, "_tx"},   c, tx,   (c < 40) ? fr[c/4] : 1'b1);
      chk({name, "_busy"}, c, busy, (c < 40));
      chk({name, "_done"}, c, done, (c == 40));
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    clear = 1'b0;
    din   = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_tx",   c, tx,   1'b1);
      chk("rst_busy", c, busy, 1'b0);
      chk("rst_done", c, done, 1'b0);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 3; c < 10; c++) begin
      @(negedge clk);
      chk("rst_idle_tx",   c, tx,   1'b1);
      chk("rst_idle_busy", c, busy, 1'b0);
    end
  endtask

  task automatic test_single();
    send_frame("single", 8'hA5, FR_A5, -10);
  endtask

  task automatic test_ignore_busy();
    send_frame("ignore", 8'h3C, FR_3C, 11);
  endtask

  task automatic test_back_to_back();
    int n_done;
    logic exp_tx;
    logic exp_busy;
    n_done = 0;
    din    = 8'h00;
    start  = 1'b1;
    for (int c = 0; c <= 84; c++) begin
      @(negedge clk);
      if (c == 0) din = 8'hFF;
      if (c == 41) begin
        start = 1'b0;
        din   = 8'h00;
      end
      if (c < 40) begin
        exp_tx = FR_00[c/4];
        exp_busy = 1'b1;
      end else if (c == 40) begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end else if (c < 81) begin
        exp_tx = FR_FF[(c-41)/4];
        exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end
      if (done === 1'b1) n_done++;
      chk("b2b_tx",   c, tx,   exp_tx);
      chk("b2b_busy", c, busy, exp_busy);
      chk("b2b_done", c, done, (c == 40) || (c == 81));
    end
    total++;
    if (n_done !== 2) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
  endtask

  task automatic test_clear();
    din   = 8'h55;
    start = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 17) clear = 1'b1;
      if (c == 18) clear = 1'b0;
      chk("clr_tx",   c, tx,   (c < 18) ? FR_55[c/4] : 1'b1);
      chk("clr_busy", c, busy, (c < 18));
      chk("clr_done", c, done, 1'b0);
    end
    send_frame("after_clr", 8'h81, FR_81, -10);
  endtask

  task automatic test_reset_in_stop();
    din   = 8'hA5;
    start = 1'b1;
    for (int c = 0; c <= 46; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 37) rst = 1'b1;
      if (c == 38) rst = 1'b0;
      chk("rstop_tx",   c, tx,   (c < 38) ? FR_A5[c/4] : 1'b1);
      chk("rstop_busy", c, busy, (c < 38));
      chk("rstop_done", c, done, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore_busy();
    test_back_to_back();
    @(negedge clk);
    test_clear();
    test_reset_in_stop();
    send_frame("after_rst", 8'h3C, FR_3C, -10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
